// File: rtl/serial_cpu_core_n.sv
// Bit-serial 4-register CPU core: each instruction is loaded into operand shift
// registers and executed LSB-first, one bit per clock, over WIDTH cycles.
module serial_cpu_core_n #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LI   = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_instr;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_flag;
  logic             r_zero_flag;

  logic [3:0]       w_op;
  logic [1:0]       w_rd;
  logic [1:0]       w_rs1;
  logic [1:0]       w_rs2;
  logic [WIDTH-1:0] w_imm;
  logic             w_transfer;
  logic             w_last_bit;
  logic             w_arith;
  logic             w_writes;
  logic             w_bit;
  logic             w_cout;
  logic             w_b_eff;
  logic [WIDTH-1:0] w_res_final;

  assign w_op        = r_instr[15:12];
  assign w_rd        = r_instr[11:10];
  assign w_rs1       = r_instr[9:8];
  assign w_rs2       = r_instr[7:6];
  assign w_imm       = WIDTH'(r_instr[7:0]);
  assign w_transfer  = instr_valid && instr_ready;
  assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));
  assign w_arith     = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ADDI);
  assign w_writes    = !r_instr[15] && (w_op != OP_NOP);
  assign w_res_final = {w_bit, r_shift[WIDTH-1:1]};

  // One-bit ALU; carry is held for opcodes that do not produce one.
  always_comb begin
    w_b_eff = r_b[0];
    w_bit   = 1'b0;
    w_cout  = r_carry;
    case (w_op)
      OP_ADD, OP_ADDI, OP_SUB: begin
        if (w_op == OP_SUB) w_b_eff = ~r_b[0];
        w_bit  = r_a[0] ^ w_b_eff ^ r_carry;
        w_cout = (r_a[0] & w_b_eff) | (r_a[0] & r_carry) | (w_b_eff & r_carry);
      end
      OP_AND:  w_bit = r_a[0] & r_b[0];
      OP_OR:   w_bit = r_a[0] | r_b[0];
      OP_XOR:  w_bit = r_a[0] ^ r_b[0];
      OP_LI:   w_bit = r_b[0];
      OP_NOP:  w_bit = r_a[0];
      default: w_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_transfer) w_state_next = LOAD;
      LOAD:    w_state_next = EXEC;
      EXEC:    if (w_last_bit) w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_instr      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_result     <= '0;
      r_carry_flag <= 1'b0;
      r_zero_flag  <= 1'b1;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_transfer) r_instr <= instr;
        LOAD: begin
          r_a     <= r_regs[w_rs1];
          r_b     <= ((w_op == OP_ADDI) || (w_op == OP_LI)) ? w_imm : r_regs[w_rs2];
          r_cnt   <= '0;
          r_carry <= (w_op == OP_SUB);
        end
        EXEC: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_shift <= w_res_final;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last_bit) begin
            r_result <= w_res_final;
            if (w_writes) r_zero_flag <= (w_res_final == '0);
            if (w_arith)  r_carry_flag <= w_cout;
          end
        end
        WB: if (w_writes) r_regs[w_rd] <= r_result;
        default: ;
      endcase
    end
  end

  assign instr_ready = rstn && (r_state == IDLE);
  assign done        = (r_state == WB);
  assign illegal     = (r_state == WB) && r_instr[15];
  assign result      = r_result;
  assign carry_flag  = r_carry_flag;
  assign zero_flag   = r_zero_flag;
  assign dbg_data    = r_regs[dbg_sel];

endmodule
